uart_rx: RTL and testbench

//  UART 8N1 receiver for the RISC-V single-cycle SoC. Samples the asynchronous serial

---
 rtl/uart_rx_pkg.sv | 21 ++
 rtl/uart_rx_sync2.sv | 22 ++
 rtl/uart_rx.sv | 128 ++++++++++++
 tb/tb_uart_rx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encoding, default line timing and the
// clocks-per-bit helper used by the receiver and transmitter.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StData  = 3'd2,
        StStop  = 3'd3,
        StBreak = 3'd4
    } uart_state_e;

    localparam int unsigned DEFAULT_CLK_FREQ = 50_000_000;
    localparam int unsigned DEFAULT_BAUD     = 9600;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle
// (high) level so no false start bit is seen coming out of reset.
module uart_rx_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: mid-bit sampling, LSB-first assembly, holding register with
// valid/ack handshake, sticky framing and overrun flags.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEFAULT_CLK_FREQ,
    parameter int unsigned BAUD     = DEFAULT_BAUD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rx_ack,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_s;
    uart_state_e   state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    uart_rx_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= StIdle;
            timer     <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // Clears first so that a set event later in this block takes priority.
            if (err_clr) begin
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end
            if (rx_ack && rx_valid) begin
                rx_valid <= 1'b0;
            end

            unique case (state)
                StIdle: begin
                    if (!rx_s) begin
                        state <= StStart;
                        timer <= HALF_LOAD;
                        busy  <= 1'b1;
                    end
                end
                StStart: begin
                    if (timer == '0) begin
                        if (!rx_s) begin
                            state   <= StData;
                            bit_idx <= 3'd0;
                            timer   <= FULL_LOAD;
                        end else begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                StData: begin
                    if (timer == '0) begin
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        timer   <= FULL_LOAD;
                        if (bit_idx == 3'd7) begin
                            state <= StStop;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                StStop: begin
                    if (timer == '0) begin
                        if (rx_s) begin
                            if (!rx_valid || rx_ack) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                            state <= StIdle;
                            busy  <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= StBreak;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                StBreak: begin
                    // A held-low line must return high before a new start bit counts.
                    if (rx_s) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized traffic against a
// frame-level model of the holding register and error flags.
module tb_uart_rx;

    localparam int unsigned CLK_FREQ = 1_600_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int unsigned BIT      = CLK_FREQ / BAUD;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rx_ack;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the consumer-visible state.
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_fe;
    logic       m_ov;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_ack    (rx_ack),
        .err_clr   (err_clr),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, 32'(rx_valid), 32'(m_valid));
        check({tag, ".data"}, 32'(rx_data), 32'(m_data));
        check({tag, ".frame_err"}, 32'(frame_err), 32'(m_fe));
        check({tag, ".overrun"}, 32'(overrun), 32'(m_ov));
        check({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop_ok);
        if (stop_ok) begin
            if (!m_valid) begin
                m_data  = b;
                m_valid = 1'b1;
            end else begin
                m_ov = 1'b1;
            end
        end else begin
            m_fe = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_fe    = 1'b0;
        m_ov    = 1'b0;
    endtask

    task automatic hold(input logic v, input int unsigned cycles);
        rx = v;
        repeat (cycles) @(negedge clk);
    endtask

    // Full frame; a bad stop bit is followed by a line held low for three bit times.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(b[i], BIT);
        hold(stop_ok, BIT);
        if (!stop_ok) begin
            hold(1'b0, BIT);
            check("break.busy", 32'(busy), 32'd1);
            hold(1'b0, 2 * BIT);
        end
        hold(1'b1, 6);
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic do_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_fe = 1'b0;
        m_ov = 1'b0;
    endtask

    initial begin
        int unsigned lat;
        logic        seen;
        logic [7:0]  b;
        logic        ok;

        reset   = 1'b1;
        rx      = 1'b1;
        rx_ack  = 1'b0;
        err_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Frame 0x03 with latency measurement, then a single-cycle ack.
        lat = 0;
        fork
            send_frame(8'h03, 1'b1);
            begin
                while (!rx_valid && lat < 400) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check("latency_in_window", 32'(lat >= 153 && lat <= 156), 32'd1);
        model_frame(8'h03, 1'b1);
        check_all("f03");
        do_ack();
        check("f03.ack", 32'(rx_valid), 32'd0);

        // Back-to-back 0x55 / 0xAA with acks.
        send_frame(8'h55, 1'b1);
        model_frame(8'h55, 1'b1);
        check_all("f55");
        do_ack();
        send_frame(8'hAA, 1'b1);
        model_frame(8'hAA, 1'b1);
        check_all("fAA");
        do_ack();

        // Short low glitch: START must reject it.
        seen = 1'b0;
        rx = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (i == 3) rx = 1'b1;
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        check("glitch.busy_pulse", 32'(seen), 32'd1);
        check_all("glitch");

        // Bad stop bit into a held-low line, then a good frame.
        send_frame(8'hA5, 1'b0);
        model_frame(8'hA5, 1'b0);
        check_all("fA5_badstop");
        send_frame(8'h3C, 1'b1);
        model_frame(8'h3C, 1'b1);
        check_all("f3C");
        do_ack();
        do_clr();
        check_all("clr1");

        // Overrun: unacked 0x11 followed by 0x22.
        send_frame(8'h11, 1'b1);
        model_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        model_frame(8'h22, 1'b1);
        check_all("overrun");
        do_clr();
        check_all("overrun.clr");
        do_ack();

        // Reset during data bit 4 of 0x7E.
        b = 8'h7E;
        hold(1'b0, BIT);
        for (int i = 0; i < 4; i++) hold(b[i], BIT);
        hold(b[4], BIT / 2);
        reset = 1'b1;
        #1;
        model_reset();
        check_all("midreset");
        @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        send_frame(8'h81, 1'b1);
        model_frame(8'h81, 1'b1);
        check_all("f81");

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) != 0) do_ack();
            if ($urandom_range(0, 5) == 0) do_clr();
            send_frame(b, ok);
            model_frame(b, ok);
            check_all("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
